d_pr_ps_ctrl: RTL and testbench

Round-robin access controller for a W-bit bank of `d_pr_ps` cells: D flip-flops with asynchronous active-high preset (`pr`, forces q=1) and clear (`ps`, forces q=0).
- Up to NREQ requesters share the bank; each may ask to load, set bits, clear bits, or read back.
- The controller serialises requests and drives the bank's `d`, `pr` and `ps` pins.
- It also makes sure `pr`/`ps` are clean, registered, one-cycle pulses that are never asserted together on the same bit.

---
 rtl/d_pr_ps_ctrl_if.sv | 16 +
 rtl/d_pr_ps_ctrl.sv | 143 ++++++++++++++
 tb/tb_d_pr_ps_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/d_pr_ps_ctrl_if.sv
// Requester-side bundle for d_pr_ps_ctrl: request/opcode/operand in, grant/ack/readback out.
interface d_pr_ps_ctrl_if #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] op;
  logic [W*NREQ-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rdata;
  logic              busy;

  modport master (output req, op, wdata, input gnt, ack, rdata, busy);
  modport slave  (input req, op, wdata, output gnt, ack, rdata, busy);
endinterface

// File: rtl/d_pr_ps_ctrl.sv
// Round-robin access controller for a bank of D flops with async preset/clear.
// Serialises load/set/clear/read requests and issues clean one-cycle pr/ps pulses.
module d_pr_ps_ctrl #(
  parameter int unsigned W    = 4,
  parameter int unsigned NREQ = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  d_pr_ps_ctrl_if.slave         rq,
  input  logic [W-1:0]          q,
  output logic [W-1:0]          d,
  output logic [W-1:0]          pr,
  output logic [W-1:0]          ps
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, ACK} state_e;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_SET = 2'b01, OP_CLR = 2'b10, OP_READ = 2'b11} op_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_q, win_d;
  op_e               op_q, op_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [W-1:0]      rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic [W-1:0]      pr_q, pr_d;
  logic [W-1:0]      ps_q, ps_d;

  logic              arb_valid;
  logic [IW-1:0]     arb_idx;
  logic [IW-1:0]     cand;
  op_e               sel_op;
  logic [W-1:0]      sel_wdata;

  // Round-robin search starting at ptr_q, plus operand mux for the winner
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    sel_op    = OP_LOAD;
    sel_wdata = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!arb_valid && rq.req[cand]) begin
        arb_valid = 1'b1;
        arb_idx   = cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IW'(i) == arb_idx) begin
        sel_op    = op_e'(rq.op[2*i +: 2]);
        sel_wdata = rq.wdata[W*i +: W];
      end
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    busy_d  = busy_q;
    pr_d    = '0;
    ps_d    = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          state_d = EXEC;
          win_d   = arb_idx;
          op_d    = sel_op;
          wdata_d = sel_wdata;
          gnt_d   = NREQ'(1) << arb_idx;
          busy_d  = 1'b1;
          if (sel_op == OP_SET) pr_d = sel_wdata;
          if (sel_op == OP_CLR) ps_d = sel_wdata;
        end
      end
      EXEC: begin
        state_d = ACK;
        ack_d   = NREQ'(1) << win_q;
        if (op_q == OP_READ) rdata_d = q;
      end
      ACK: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
        ptr_d   = (32'(win_q) == NREQ - 1) ? '0 : win_q + IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset kills any in-flight pulse at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      op_q    <= OP_LOAD;
      wdata_q <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      pr_q    <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      pr_q    <= pr_d;
      ps_q    <= ps_d;
    end
  end

  // Bank D input: load data during a load EXEC, otherwise recirculate q
  always_comb begin
    d = (state_q == EXEC && op_q == OP_LOAD) ? wdata_q : q;
  end

  assign pr       = pr_q;
  assign ps       = ps_q;
  assign rq.gnt   = gnt_q;
  assign rq.ack   = ack_q;
  assign rq.rdata = rdata_q;
  assign rq.busy  = busy_q;

endmodule

// File: tb/tb_d_pr_ps_ctrl.sv
// Scoreboard bench for d_pr_ps_ctrl driving a behavioural d_pr_ps bank.
module tb_d_pr_ps_ctrl;
  localparam int unsigned W    = 4;
  localparam int unsigned NREQ = 4;
  localparam logic [1:0] LD = 2'b00, ST = 2'b01, CL = 2'b10, RD = 2'b11;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] q, d, pr, ps;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int          idx;
    logic [W-1:0] q;
    logic [W-1:0] rd;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] rd_model = '0;

  d_pr_ps_ctrl_if #(.W(W), .NREQ(NREQ)) bus ();

  d_pr_ps_ctrl #(.W(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .rq(bus), .q(q), .d(d), .pr(pr), .ps(ps)
  );

  always #5 clk = ~clk;

  // Behavioural bank: clear wins over preset, both asynchronous
  for (genvar i = 0; i < W; i++) begin : g_cell
    logic cq = 1'b0;
    always @(posedge clk or posedge pr[i] or posedge ps[i]) begin
      if (ps[i])      cq <= 1'b0;
      else if (pr[i]) cq <= 1'b1;
      else            cq <= d[i];
    end
    assign q[i] = cq;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle invariants and in-order ack scoreboard
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("pr_ps_excl", 32'(pr & ps), 32'd0);
      chk("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      if (|bus.ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(bus.ack), 32'd0);
        end else begin
          mon_e = sb.pop_front();
          chk("ack_idx", 32'(bus.ack), 32'd1 << mon_e.idx);
          chk("ack_q", 32'(q), 32'(mon_e.q));
          chk("ack_rdata", 32'(bus.rdata), 32'(mon_e.rd));
        end
      end
    end
  end

  task automatic run_op(input int i, input logic [1:0] o, input logic [W-1:0] wd, input logic [W-1:0] eq);
    exp_t e;
    if (o == RD) rd_model = eq;
    e.idx = i; e.q = eq; e.rd = rd_model;
    sb.push_back(e);
    bus.op[2*i +: 2]    = o;
    bus.wdata[W*i +: W] = wd;
    bus.req[i]          = 1'b1;
    cycle();
    chk("gnt_exec", 32'(bus.gnt), 32'd1 << i);
    chk("busy_exec", 32'(bus.busy), 32'd1);
    chk("pr_exec", 32'(pr), (o == ST) ? 32'(wd) : 32'd0);
    chk("ps_exec", 32'(ps), (o == CL) ? 32'(wd) : 32'd0);
    if (o == LD) chk("d_load", 32'(d), 32'(wd));
    cycle();
    chk("pr_ack", 32'(pr), 32'd0);
    chk("ps_ack", 32'(ps), 32'd0);
    chk("gnt_ack", 32'(bus.gnt), 32'd1 << i);
    bus.req[i] = 1'b0;
    cycle();
    chk("gnt_idle", 32'(bus.gnt), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("d_feedback", 32'(d), 32'(q));
  endtask

  initial begin
    exp_t e;
    int acks;
    int ng;
    int last_t;
    logic [NREQ-1:0] reraise;
    logic [NREQ-1:0] prev_gnt;
    int order [5];
    order = '{0, 1, 2, 3, 0};

    rst       = 1'b0;
    bus.req   = '0;
    bus.op    = '0;
    bus.wdata = '0;
    repeat (2) cycle();
    chk("rst_gnt", 32'(bus.gnt), 32'd0);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pr", 32'(pr), 32'd0);
    chk("rst_ps", 32'(ps), 32'd0);
    chk("rst_rdata", 32'(bus.rdata), 32'd0);
    chk("rst_d", 32'(d), 32'(q));
    rst = 1'b1;
    cycle();

    // Reset during a set EXEC: pulse truncated, no ack
    bus.op[1:0]    = ST;
    bus.wdata[3:0] = 4'hF;
    bus.req[0]     = 1'b1;
    cycle();
    chk("mid_pr", 32'(pr), 32'hF);
    chk("mid_gnt", 32'(bus.gnt), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_pr", 32'(pr), 32'd0);
    chk("mid_rst_ps", 32'(ps), 32'd0);
    chk("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    chk("mid_rst_ack", 32'(bus.ack), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_q", 32'(q), 32'hF);
    bus.req = '0;
    @(negedge clk);
    rst = 1'b1;
    cycle();

    // First arbitration after reset favours req0, then req1
    bus.op    = '0;
    bus.wdata = '0;
    e.idx = 0; e.q = 4'h0; e.rd = 4'h0; sb.push_back(e);
    e.idx = 1; e.q = 4'h0; e.rd = 4'h0; sb.push_back(e);
    bus.req = 4'b0011;
    cycle();
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    cycle();
    bus.req[0] = 1'b0;
    cycle();
    cycle();
    chk("second_gnt", 32'(bus.gnt), 32'h2);
    cycle();
    bus.req[1] = 1'b0;
    cycle();

    // Load, set/clear, read with hold, zero mask
    run_op(0, LD, 4'hA, 4'hA);
    run_op(1, LD, 4'h0, 4'h0);
    run_op(1, ST, 4'h5, 4'h5);
    run_op(1, CL, 4'h4, 4'h1);
    run_op(2, LD, 4'h9, 4'h9);
    run_op(2, RD, 4'h0, 4'h9);
    run_op(3, LD, 4'h3, 4'h3);
    chk("rdata_hold", 32'(bus.rdata), 32'h9);
    run_op(3, ST, 4'h0, 4'h3);

    // Round-robin with all four requesters contending
    bus.op    = '0;
    bus.wdata = {4'h8, 4'h4, 4'h2, 4'h1};
    for (int k = 0; k < 5; k++) begin
      e.idx = order[k];
      e.q   = W'(4'h1 << order[k]);
      e.rd  = rd_model;
      sb.push_back(e);
    end
    bus.req  = 4'hF;
    acks     = 0;
    ng       = 0;
    last_t   = 0;
    reraise  = '0;
    prev_gnt = '0;
    for (int c = 0; c < 60 && acks < 5; c++) begin
      cycle();
      bus.req = bus.req | reraise;
      reraise = '0;
      if (prev_gnt == '0 && bus.gnt != '0) begin
        if (ng < 5) chk("rr_order", 32'(bus.gnt), 32'd1 << order[ng]);
        if (ng > 0) chk("rr_interval", 32'(c - last_t), 32'd3);
        last_t = c;
        ng++;
      end
      prev_gnt = bus.gnt;
      if (|bus.ack) begin
        acks++;
        if (acks < 5) begin
          reraise = bus.ack;
          bus.req = bus.req & ~bus.ack;
        end else begin
          bus.req = '0;
        end
      end
    end
    chk("rr_acks", 32'(acks), 32'd5);

    repeat (4) cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
